// File: rtl/oam_dmc_dma_arbiter_pkg.sv
// Shared CPU-bus DMA definitions: arbiter state encoding and the register addresses
// that the cpu_memory decode also uses.
package oam_dmc_dma_arbiter_pkg;

  localparam logic [15:0] DMA_TRIG_ADDR = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
  localparam int          PAGE_BYTES    = 256;
  localparam int          CNT_W         = $clog2(PAGE_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HALT     = 3'd1,
    ST_ALIGN    = 3'd2,
    ST_GET      = 3'd3,
    ST_PUT      = 3'd4,
    ST_DMC_HALT = 3'd5,
    ST_DMC_READ = 3'd6,
    ST_DMC_DONE = 3'd7
  } dma_state_t;

endpackage

// File: rtl/oam_dmc_dma_arbiter_dma_bus_mux.sv
// Selects what drives cpu_memory: the CPU in IDLE, otherwise the active DMA engine.
// Any stalled cycle that is not a real transfer becomes a dummy read of cpu_addr.
module oam_dmc_dma_arbiter_dma_bus_mux
  import oam_dmc_dma_arbiter_pkg::*;
(
  input  dma_state_t       state,
  input  logic             dmc_req,
  input  logic [15:0]      cpu_addr,
  input  logic             cpu_r_en,
  input  logic [7:0]       cpu_w_data,
  input  logic [15:0]      dmc_addr,
  input  logic [7:0]       page,
  input  logic [CNT_W-1:0] cnt,
  input  logic [7:0]       mem_r_data,
  output logic [15:0]      mem_addr,
  output logic             mem_r_en,
  output logic [7:0]       mem_w_data
);

  always_comb begin
    mem_addr   = cpu_addr;
    mem_r_en   = 1'b1;
    mem_w_data = 8'h00;
    case (state)
      ST_IDLE: begin
        mem_r_en   = cpu_r_en;
        mem_w_data = cpu_w_data;
      end
      // A pending DMC fetch steals this GET slot, which then degrades to a dummy read.
      ST_GET:      if (!dmc_req) mem_addr = {page, cnt};
      ST_PUT: begin
        mem_addr   = OAM_DATA_ADDR;
        mem_r_en   = 1'b0;
        mem_w_data = mem_r_data;
      end
      ST_DMC_READ: mem_addr = dmc_addr;
      default: ;
    endcase
  end

endmodule

// File: rtl/oam_dmc_dma_arbiter.sv
// OAM/DMC DMA arbiter on the CPU memory bus; stalls the CPU while either engine runs.
// Build option OAM_DMA_ALIGN_EN adds the odd-cycle ALIGN state (514-cycle transfers).
module oam_dmc_dma_arbiter
  import oam_dmc_dma_arbiter_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clock_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_r_en,
  input  logic [7:0]  cpu_w_data,
  output logic        cpu_stall,
  output logic [15:0] mem_addr,
  output logic        mem_r_en,
  output logic [7:0]  mem_w_data,
  input  logic [7:0]  mem_r_data,
  input  logic        dmc_req,
  input  logic [15:0] dmc_addr,
  output logic        dmc_ack,
  output logic [7:0]  dmc_data,
  output dma_state_t  state_dbg
);

  // DMC handshake: dmc_req is a level held by the APU; the fetch completes in the
  // single cycle dmc_ack is high, dmc_data is valid only then, and the APU drops
  // dmc_req before the next enabled edge.

  dma_state_t       state, next_state, ret_state, next_ret;
  logic [7:0]       page;
  logic [CNT_W-1:0] cnt;
  logic             oam_trig;
  logic             halt_to_align;

  assign oam_trig = (cpu_addr == DMA_TRIG_ADDR) && !cpu_r_en;

`ifdef OAM_DMA_ALIGN_EN
  logic parity;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      parity <= 1'b0;
    else if (clock_en) parity <= ~parity;
  end

  assign halt_to_align = parity;
`else
  assign halt_to_align = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ret_state <= ST_GET;
    end else if (clock_en) begin
      state     <= next_state;
      ret_state <= next_ret;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      page <= 8'h00;
      cnt  <= '0;
    end else if (clock_en) begin
      if (state == ST_IDLE && oam_trig) page <= cpu_w_data;
      if (state == ST_PUT)              cnt  <= cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    next_ret   = ret_state;
    case (state)
      ST_IDLE: begin
        if (oam_trig)     next_state = ST_HALT;
        else if (dmc_req) next_state = ST_DMC_HALT;
      end
      ST_HALT:  next_state = halt_to_align ? ST_ALIGN : ST_GET;
      ST_ALIGN: next_state = ST_GET;
      ST_GET: begin
        if (dmc_req) begin
          next_ret   = ST_GET;
          next_state = ST_DMC_READ;
        end else begin
          next_state = ST_PUT;
        end
      end
      ST_PUT:      next_state = (cnt == CNT_W'(PAGE_BYTES - 1)) ? ST_IDLE : ST_GET;
      ST_DMC_HALT: begin
        next_ret   = ST_IDLE;
        next_state = ST_DMC_READ;
      end
      ST_DMC_READ: next_state = ST_DMC_DONE;
      ST_DMC_DONE: next_state = ret_state;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = (state != ST_IDLE);
    dmc_ack   = (state == ST_DMC_DONE);
    dmc_data  = (state == ST_DMC_DONE) ? mem_r_data : 8'h00;
    state_dbg = state;
  end

  oam_dmc_dma_arbiter_dma_bus_mux u_bus_mux (
    .state      (state),
    .dmc_req    (dmc_req),
    .cpu_addr   (cpu_addr),
    .cpu_r_en   (cpu_r_en),
    .cpu_w_data (cpu_w_data),
    .dmc_addr   (dmc_addr),
    .page       (page),
    .cnt        (cnt),
    .mem_r_data (mem_r_data),
    .mem_addr   (mem_addr),
    .mem_r_en   (mem_r_en),
    .mem_w_data (mem_w_data)
  );

endmodule
